// File: rtl/udma_pkg.sv
// Shared uDMA channel types and widths, extended with the linear address generator's
// state and beat-step types.
package udma_pkg;

  localparam int L2_AWIDTH_NOAL = 21;
  localparam int TRANS_SIZE     = 20;

  typedef logic [L2_AWIDTH_NOAL-1:0] ch_addr_t;
  typedef logic [TRANS_SIZE-1:0]     ch_transize_t;
  typedef logic [TRANS_SIZE-1:0]     ch_bytesleft_t;
  typedef logic [1:0]                ch_datasize_t;
  typedef logic [2:0]                ch_step_t;

  typedef enum logic {ADDRGEN_IDLE, ADDRGEN_RUN} ch_addrgen_state_t;

  // Datasize codes 2 and 3 both mean a 4-byte beat.
  function automatic ch_step_t datasize_to_step(input ch_datasize_t ds);
    ch_step_t step;
    case (ds)
      2'd0:    step = 3'd1;
      2'd1:    step = 3'd2;
      2'd2:    step = 3'd4;
      default: step = 3'd4;
    endcase
    return step;
  endfunction

endpackage

// File: rtl/udma_ch_addrgen.sv
// Linear uDMA channel address generator: per-beat address/bytes-left tracking with one
// queued (shadow) transfer and optional auto-reload of the last loaded config.
module udma_ch_addrgen
  import udma_pkg::*;
#(
  parameter int L2_AWIDTH_NOAL = udma_pkg::L2_AWIDTH_NOAL,
  parameter int TRANS_SIZE     = udma_pkg::TRANS_SIZE
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_startaddr_i,
  input  logic [TRANS_SIZE-1:0]     cfg_size_i,
  input  logic [1:0]                cfg_datasize_i,
  input  logic                      cfg_continuous_i,
  input  logic                      cfg_en_i,
  input  logic                      cfg_clr_i,
  input  logic                      xfer_i,
  output logic [L2_AWIDTH_NOAL-1:0] ch_addr_o,
  output logic [TRANS_SIZE-1:0]     ch_bytes_left_o,
  output logic [1:0]                ch_datasize_o,
  output logic                      ch_busy_o,
  output logic                      ch_pending_o,
  output logic                      ch_last_o,
  output logic                      ch_evt_o
);

  ch_addrgen_state_t         state_r;
  logic [L2_AWIDTH_NOAL-1:0] addr_r, reload_addr_r, shadow_addr_r, ld_addr_s, addr_inc_s;
  logic [TRANS_SIZE-1:0]     left_r, reload_size_r, shadow_size_r, ld_size_s, left_dec_s, step_ext_s;
  ch_datasize_t              dsize_r, shadow_dsize_r, ld_dsize_s;
  logic                      cont_r, shadow_cont_r, ld_cont_s;
  logic                      pending_r, busy_r, evt_r;
  ch_step_t                  step_s;
  logic                      last_s, en_ok_s, done_s;

  // Beat arithmetic and completion detection from the active registers.
  always_comb begin
    step_s     = datasize_to_step(dsize_r);
    step_ext_s = TRANS_SIZE'(step_s);
    addr_inc_s = addr_r + L2_AWIDTH_NOAL'(step_s);
    last_s     = busy_r & (left_r <= step_ext_s);
    left_dec_s = (left_r > step_ext_s) ? (left_r - step_ext_s) : {TRANS_SIZE{1'b0}};
    en_ok_s    = cfg_en_i & (cfg_size_i != {TRANS_SIZE{1'b0}});
    done_s     = xfer_i & last_s;
  end

  // A fresh config arriving on the completion cycle bypasses the shadow and wins over it.
  always_comb begin
    if (en_ok_s) begin
      ld_addr_s  = cfg_startaddr_i;
      ld_size_s  = cfg_size_i;
      ld_dsize_s = cfg_datasize_i;
      ld_cont_s  = cfg_continuous_i;
    end else begin
      ld_addr_s  = shadow_addr_r;
      ld_size_s  = shadow_size_r;
      ld_dsize_s = shadow_dsize_r;
      ld_cont_s  = shadow_cont_r;
    end
  end

  // Channel state machine with active, shadow and reload register groups.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r        <= ADDRGEN_IDLE;
      addr_r         <= {L2_AWIDTH_NOAL{1'b0}};
      left_r         <= {TRANS_SIZE{1'b0}};
      dsize_r        <= 2'd0;
      cont_r         <= 1'b0;
      reload_addr_r  <= {L2_AWIDTH_NOAL{1'b0}};
      reload_size_r  <= {TRANS_SIZE{1'b0}};
      shadow_addr_r  <= {L2_AWIDTH_NOAL{1'b0}};
      shadow_size_r  <= {TRANS_SIZE{1'b0}};
      shadow_dsize_r <= 2'd0;
      shadow_cont_r  <= 1'b0;
      pending_r      <= 1'b0;
      busy_r         <= 1'b0;
      evt_r          <= 1'b0;
    end else if (cfg_clr_i) begin
      state_r   <= ADDRGEN_IDLE;
      addr_r    <= {L2_AWIDTH_NOAL{1'b0}};
      left_r    <= {TRANS_SIZE{1'b0}};
      pending_r <= 1'b0;
      busy_r    <= 1'b0;
      evt_r     <= 1'b0;
    end else begin
      evt_r <= 1'b0;
      case (state_r)
        ADDRGEN_IDLE: begin
          if (en_ok_s) begin
            addr_r        <= ld_addr_s;
            left_r        <= ld_size_s;
            dsize_r       <= ld_dsize_s;
            cont_r        <= ld_cont_s;
            reload_addr_r <= ld_addr_s;
            reload_size_r <= ld_size_s;
            state_r       <= ADDRGEN_RUN;
            busy_r        <= 1'b1;
          end
        end
        ADDRGEN_RUN: begin
          if (done_s) begin
            evt_r     <= 1'b1;
            pending_r <= 1'b0;
            if (en_ok_s || pending_r) begin
              addr_r        <= ld_addr_s;
              left_r        <= ld_size_s;
              dsize_r       <= ld_dsize_s;
              cont_r        <= ld_cont_s;
              reload_addr_r <= ld_addr_s;
              reload_size_r <= ld_size_s;
            end else if (cont_r) begin
              addr_r <= reload_addr_r;
              left_r <= reload_size_r;
            end else begin
              addr_r  <= addr_inc_s;
              left_r  <= left_dec_s;
              state_r <= ADDRGEN_IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            if (xfer_i) begin
              addr_r <= addr_inc_s;
              left_r <= left_dec_s;
            end
            if (en_ok_s) begin
              shadow_addr_r  <= cfg_startaddr_i;
              shadow_size_r  <= cfg_size_i;
              shadow_dsize_r <= cfg_datasize_i;
              shadow_cont_r  <= cfg_continuous_i;
              pending_r      <= 1'b1;
            end
          end
        end
        default: begin
          state_r   <= ADDRGEN_IDLE;
          busy_r    <= 1'b0;
          pending_r <= 1'b0;
        end
      endcase
    end
  end

  assign ch_addr_o       = addr_r;
  assign ch_bytes_left_o = left_r;
  assign ch_datasize_o   = dsize_r;
  assign ch_busy_o       = busy_r;
  assign ch_pending_o    = pending_r;
  assign ch_last_o       = last_s;
  assign ch_evt_o        = evt_r;

endmodule
